// File: rtl/fpu_d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_d_pkg
// Description : Shared types and constants for the sequential binary64
//               divider: FSM state encoding, rounding-mode codes, fflags
//               bit positions and the special result encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_DIVIDE = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [63:0] CANON_NAN  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] MAX_FINITE = 64'h7FEF_FFFF_FFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/fpu_d_round.sv
`default_nettype none
// ============================================================================
// Module      : fpu_d_round
// Description : Combinational rounding of a normalised quotient plus
//               overflow / underflow result selection and flag generation.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_d_round
  import fpu_d_pkg::*;
(
  input  logic               sign_i,
  input  logic signed [12:0] exp_i,
  input  logic [52:0]        mant_i,
  input  logic               guard_i,
  input  logic               round_i,
  input  logic               sticky_i,
  input  logic [2:0]         rm_i,
  output logic [63:0]        result_o,
  output logic [4:0]         fflags_o
);

  logic               w_inexact;
  logic               w_inc;
  logic               w_to_inf;
  logic [53:0]        w_mant_r;
  logic               w_carry;
  logic signed [12:0] w_exp_r;
  logic [51:0]        w_frac;

  // Increment decision, rounded mantissa/exponent and final result selection
  always_comb begin
    w_inexact = guard_i | round_i | sticky_i;
    // Unlisted rm codes fall into the default arm and behave as RNE.
    case (rm_i)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = sign_i & w_inexact;
      RM_RUP:  w_inc = ~sign_i & w_inexact;
      RM_RMM:  w_inc = guard_i;
      default: w_inc = guard_i & (round_i | sticky_i | mant_i[0]);
    endcase
    case (rm_i)
      RM_RTZ:  w_to_inf = 1'b0;
      RM_RDN:  w_to_inf = sign_i;
      RM_RUP:  w_to_inf = ~sign_i;
      default: w_to_inf = 1'b1;
    endcase

    w_mant_r = {1'b0, mant_i} + {53'd0, w_inc};
    w_carry  = w_mant_r[53];
    // A carry out means the mantissa rolled over to exactly 2.0.
    w_frac   = w_carry ? 52'd0 : w_mant_r[51:0];
    w_exp_r  = exp_i + $signed({12'd0, w_carry});

    fflags_o = 5'd0;
    if (w_exp_r >= 13'sd2047) begin
      fflags_o[FLAG_OF] = 1'b1;
      fflags_o[FLAG_NX] = 1'b1;
      result_o = w_to_inf ? {sign_i, 11'h7FF, 52'd0} : {sign_i, MAX_FINITE[62:0]};
    end else if (w_exp_r <= 13'sd0) begin
      fflags_o[FLAG_UF] = 1'b1;
      fflags_o[FLAG_NX] = 1'b1;
      result_o = {sign_i, 63'd0};
    end else begin
      fflags_o[FLAG_NX] = w_inexact;
      result_o = {sign_i, w_exp_r[10:0], w_frac};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_d_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpu_d_div_seq
// Description : Sequential IEEE-754 binary64 divider, one restoring-division
//               quotient bit per cycle, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_d_div_seq
  import fpu_d_pkg::*;
#(
  parameter int ITER_BITS = 56
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic [4:0]  fflags
);

  localparam int CW = $clog2(ITER_BITS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER_BITS - 1);

  state_e                state_q, state_d;
  logic [63:0]           a_q, a_d, b_q, b_d;
  logic [2:0]            rm_q, rm_d;
  logic                  sign_q, sign_d;
  logic signed [12:0]    exp_q, exp_d;
  logic [53:0]           rem_q, rem_d;
  logic [52:0]           div_q, div_d;
  logic [ITER_BITS-1:0]  quo_q, quo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [63:0]           result_q, result_d;
  logic [4:0]            fflags_q, fflags_d;

  logic                  w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2, w_snan;
  logic                  w_sign, w_special;
  logic [63:0]           w_sp_res;
  logic [4:0]            w_sp_flg;
  logic signed [12:0]    w_exp;
  logic                  w_ge;
  logic [53:0]           w_rem_sel;
  logic [ITER_BITS-1:0]  w_norm;
  logic signed [12:0]    w_exp_n;
  logic                  w_sticky;
  logic [63:0]           w_rnd_res;
  logic [4:0]            w_rnd_flg;

  // Operand classification and special-case result (subnormals read as zero)
  always_comb begin
    w_zero1 = (a_q[62:52] == 11'd0);
    w_zero2 = (b_q[62:52] == 11'd0);
    w_inf1  = (&a_q[62:52]) & (a_q[51:0] == 52'd0);
    w_inf2  = (&b_q[62:52]) & (b_q[51:0] == 52'd0);
    w_nan1  = (&a_q[62:52]) & (|a_q[51:0]);
    w_nan2  = (&b_q[62:52]) & (|b_q[51:0]);
    w_snan  = (w_nan1 & ~a_q[51]) | (w_nan2 & ~b_q[51]);
    w_sign  = a_q[63] ^ b_q[63];
    w_exp   = $signed({2'b00, a_q[62:52]}) - $signed({2'b00, b_q[62:52]}) + 13'sd1023;

    w_special = 1'b1;
    w_sp_res  = 64'd0;
    w_sp_flg  = 5'd0;
    if (w_nan1 | w_nan2) begin
      w_sp_res         = CANON_NAN;
      w_sp_flg[FLAG_NV] = w_snan;
    end else if ((w_inf1 & w_inf2) | (w_zero1 & w_zero2)) begin
      w_sp_res         = CANON_NAN;
      w_sp_flg[FLAG_NV] = 1'b1;
    end else if (w_inf1) begin
      w_sp_res = {w_sign, 11'h7FF, 52'd0};
    end else if (w_inf2 | w_zero1) begin
      w_sp_res = {w_sign, 63'd0};
    end else if (w_zero2) begin
      w_sp_res         = {w_sign, 11'h7FF, 52'd0};
      w_sp_flg[FLAG_DZ] = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  // Restoring step and post-division normalisation
  always_comb begin
    w_ge      = (rem_q >= {1'b0, div_q});
    w_rem_sel = w_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    // Quotient lies in (0.5, 2): a clear MSB needs a one-bit left shift.
    w_norm    = quo_q[ITER_BITS-1] ? quo_q : (quo_q << 1);
    w_exp_n   = quo_q[ITER_BITS-1] ? exp_q : (exp_q - 13'sd1);
    // Bits below the round position plus any nonzero remainder form sticky.
    w_sticky  = (|rem_q) | (|(w_norm << 55));
  end

  fpu_d_round u_round (
    .sign_i   (sign_q),
    .exp_i    (w_exp_n),
    .mant_i   (w_norm[ITER_BITS-1 -: 53]),
    .guard_i  (w_norm[ITER_BITS-54]),
    .round_i  (w_norm[ITER_BITS-55]),
    .sticky_i (w_sticky),
    .rm_i     (rm_q),
    .result_o (w_rnd_res),
    .fflags_o (w_rnd_flg)
  );

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rm_d      = rm_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    div_d     = div_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    fflags_d  = fflags_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = rs1;
          b_d     = rs2;
          rm_d    = rm;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_d = w_sign;
        if (w_special) begin
          result_d = w_sp_res;
          fflags_d = w_sp_flg;
          state_d  = ST_DONE;
        end else begin
          rem_d   = {2'b01, a_q[51:0]};
          div_d   = {1'b1, b_q[51:0]};
          quo_d   = '0;
          cnt_d   = '0;
          exp_d   = w_exp;
          state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        quo_d = {quo_q[ITER_BITS-2:0], w_ge};
        rem_d = {w_rem_sel[52:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        result_d = w_rnd_res;
        fflags_d = w_rnd_flg;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rm_q     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rm_q     <= rm_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
    end
  end

  assign result = result_q;
  assign fflags = fflags_q;

endmodule
`default_nettype wire
